ppu_vram_read_arbiter: RTL and testbench

- Shares one Avalon-MM read-only master port between NUM_REQ PPU fetch clients (tile engine, sprite engine, palette/attribute fetch).
- Round-robin arbitration, one command held on the bus at a time, up to MAX_OUTSTANDING pipelined reads in flight.
- Routes each returned word back to the requester that issued it.
- Sits between the PPU fetch engines and the interconnect toward VRAM.

---
 rtl/ppu_vram_read_arbiter.sv | 159 +++++++++++++++
 tb/tb_ppu_vram_read_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_read_arbiter.sv
// Round-robin arbiter that lets several PPU fetch clients share one Avalon-MM read master.
// Accepted requester IDs are queued so each returned word goes back to the requester that issued it.
module ppu_vram_read_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk_50M,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   avm_m0_read,
    output logic [31:0]            avm_m0_address,
    input  logic [31:0]            avm_m0_readdata,
    input  logic                   avm_m0_waitrequest,
    input  logic                   avm_m0_readdatavalid,
    output logic                   busy,
    output logic                   err_unexpected
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state_reg, state_next;
    logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]    winner_reg, winner_next;
    logic [31:0]        addr_reg, addr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [NUM_REQ-1:0] rsp_valid_reg;
    logic [31:0]        rsp_data_reg;
    logic               err_reg;

    logic [ID_W-1:0]    id_fifo [MAX_OUTSTANDING];
    logic [31:0]        req_addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] pop_onehot;

    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand_idx;
    logic               accept;
    logic               pop;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_addr_arr[gi] = req_addr[32*gi +: 32];
            assign req_ready[gi]    = accept && (winner_reg == ID_W'(gi));
            assign pop_onehot[gi]   = (id_fifo[rd_ptr_reg] == ID_W'(gi));
        end
    endgenerate

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_id    = cand_idx;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        addr_next   = addr_reg;
        rr_ptr_next = rr_ptr_reg;
        accept      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_found && (count_reg < CNT_W'(MAX_OUTSTANDING))) begin
                    state_next  = ISSUE;
                    winner_next = grant_id;
                    addr_next   = req_addr_arr[grant_id];
                end
            end
            ISSUE: begin
                if (!avm_m0_waitrequest) begin
                    accept      = 1'b1;
                    state_next  = IDLE;
                    rr_ptr_next = (winner_reg == ID_W'(NUM_REQ - 1)) ? '0 : winner_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A data beat with nothing outstanding is dropped and only flags the error.
    assign pop = avm_m0_readdatavalid && (count_reg != '0);

    always_comb begin
        count_next = count_reg;
        case ({accept, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            winner_reg    <= '0;
            addr_reg      <= '0;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            winner_reg <= winner_next;
            addr_reg   <= addr_next;
            count_reg  <= count_next;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                rsp_data_reg <= avm_m0_readdata;
            end
            rsp_valid_reg <= pop ? pop_onehot : '0;
            if (avm_m0_readdatavalid && (count_reg == '0)) begin
                err_reg <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk_50M) begin
        if (accept) begin
            id_fifo[wr_ptr_reg] <= winner_reg;
        end
    end

    assign avm_m0_read    = (state_reg == ISSUE);
    assign avm_m0_address = addr_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_data       = rsp_data_reg;
    assign busy           = (state_reg == ISSUE) || (count_reg != '0);
    assign err_unexpected = err_reg;

endmodule

// File: tb/tb_ppu_vram_read_arbiter.sv
// Bench for ppu_vram_read_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based transaction model.
module tb_ppu_vram_read_arbiter;
    localparam int NUM_REQ         = 3;
    localparam int MAX_OUTSTANDING = 4;

    logic                  clk_50M = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [32*NUM_REQ-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic                  avm_m0_read;
    logic [31:0]           avm_m0_address;
    logic [31:0]           avm_m0_readdata = '0;
    logic                  avm_m0_waitrequest = 1'b0;
    logic                  avm_m0_readdatavalid = 1'b0;
    logic                  busy;
    logic                  err_unexpected;

    always #5 clk_50M = ~clk_50M;

    ppu_vram_read_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk_50M(clk_50M),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .avm_m0_read(avm_m0_read),
        .avm_m0_address(avm_m0_address),
        .avm_m0_readdata(avm_m0_readdata),
        .avm_m0_waitrequest(avm_m0_waitrequest),
        .avm_m0_readdatavalid(avm_m0_readdatavalid),
        .busy(busy),
        .err_unexpected(err_unexpected)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Transaction model: a pending command plus a queue of outstanding requester IDs.
    bit                 m_cmd;
    int                 m_id;
    logic [31:0]        m_addr;
    int                 m_rr;
    int                 m_q[$];
    bit                 m_err;
    int                 m_rsp_id;
    logic [31:0]        m_rsp_data;
    logic [NUM_REQ-1:0] m_last_ready;

    int dut_grants[$];
    int dut_accepts;

    typedef struct {
        logic [2:0]  v;
        logic [31:0] a0;
        logic        w;
        logic        dv;
        logic [31:0] d;
        logic        e_read;
        logic [31:0] e_addr;
        logic [2:0]  e_ready;
        logic [2:0]  e_rspv;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic [2:0] v, logic [31:0] a0, logic w, logic dv, logic [31:0] d,
                                logic e_read, logic [31:0] e_addr, logic [2:0] e_ready,
                                logic [2:0] e_rspv, logic [31:0] e_data, logic e_busy);
        vec_t r;
        r.v = v; r.a0 = a0; r.w = w; r.dv = dv; r.d = d;
        r.e_read = e_read; r.e_addr = e_addr; r.e_ready = e_ready;
        r.e_rspv = e_rspv; r.e_data = e_data; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_cmd = 1'b0;
        m_id = 0;
        m_addr = '0;
        m_rr = 0;
        m_q.delete();
        m_err = 1'b0;
        m_rsp_id = -1;
        m_rsp_data = '0;
        m_last_ready = '0;
    endtask

    task automatic check_model();
        logic [NUM_REQ-1:0] e_ready;
        logic [NUM_REQ-1:0] e_rspv;
        int sz0;
        e_ready = (m_cmd && !avm_m0_waitrequest) ? (NUM_REQ'(1) << m_id) : '0;
        e_rspv  = (m_rsp_id >= 0) ? (NUM_REQ'(1) << m_rsp_id) : '0;
        chk("model.read", avm_m0_read, m_cmd);
        chk("model.address", avm_m0_address, m_addr);
        chk("model.req_ready", req_ready, e_ready);
        chk("model.rsp_valid", rsp_valid, e_rspv);
        chk("model.rsp_data", rsp_data, m_rsp_data);
        chk("model.busy", busy, (m_cmd || m_q.size() != 0));
        chk("model.err", err_unexpected, m_err);
        m_last_ready = e_ready;
        // Advance one clock: responses come back in issue order, the limit is judged on the old count.
        sz0 = m_q.size();
        m_rsp_id = -1;
        if (avm_m0_readdatavalid) begin
            if (sz0 > 0) begin
                m_rsp_id = m_q.pop_front();
                m_rsp_data = avm_m0_readdata;
            end else begin
                m_err = 1'b1;
            end
        end
        if (m_cmd) begin
            if (!avm_m0_waitrequest) begin
                m_q.push_back(m_id);
                m_rr = (m_id + 1) % NUM_REQ;
                m_cmd = 1'b0;
            end
        end else if (req_valid != '0 && sz0 < MAX_OUTSTANDING) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[(m_rr + k) % NUM_REQ]) begin
                    m_id = (m_rr + k) % NUM_REQ;
                    break;
                end
            end
            m_cmd = 1'b1;
            m_addr = req_addr[32*m_id +: 32];
        end
    endtask

    task automatic step(input logic [NUM_REQ-1:0] v, input logic [32*NUM_REQ-1:0] a,
                        input logic w, input logic dv, input logic [31:0] d);
        @(posedge clk_50M);
        #1;
        req_valid = v;
        req_addr = a;
        avm_m0_waitrequest = w;
        avm_m0_readdatavalid = dv;
        avm_m0_readdata = d;
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready[k]) dut_grants.push_back(k);
        end
        if (avm_m0_read && !avm_m0_waitrequest) dut_accepts++;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rsp_valid[k]) $display("rsp id=%0d data=%h t=%0t", k, rsp_data, $time);
        end
        check_model();
    endtask

    task automatic do_reset();
        @(posedge clk_50M);
        #1;
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        avm_m0_waitrequest = 1'b0;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_readdata = '0;
        model_reset();
        @(posedge clk_50M);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step('0, '0, 1'b0, (m_q.size() > 0), $urandom);
        end
    endtask

    initial begin
        logic [32*NUM_REQ-1:0] av;
        logic [32*NUM_REQ-1:0] three_addr;
        logic [NUM_REQ-1:0]    rq_v;
        logic [32*NUM_REQ-1:0] rq_a;
        int exp_order[6];

        tbl[0]  = mk(3'b001, 32'h1000, 0, 0, 0,            0, 32'h0,    3'b000, 3'b000, 32'h0,        0);
        tbl[1]  = mk(3'b001, 32'h1000, 0, 0, 0,            1, 32'h1000, 3'b001, 3'b000, 32'h0,        1);
        tbl[2]  = mk(3'b000, 32'h0,    0, 0, 0,            0, 32'h1000, 3'b000, 3'b000, 32'h0,        1);
        tbl[3]  = mk(3'b000, 32'h0,    0, 0, 0,            0, 32'h1000, 3'b000, 3'b000, 32'h0,        1);
        tbl[4]  = mk(3'b000, 32'h0,    0, 1, 32'hDEADBEEF, 0, 32'h1000, 3'b000, 3'b000, 32'h0,        1);
        tbl[5]  = mk(3'b000, 32'h0,    0, 0, 0,            0, 32'h1000, 3'b000, 3'b001, 32'hDEADBEEF, 0);
        tbl[6]  = mk(3'b000, 32'h0,    0, 0, 0,            0, 32'h1000, 3'b000, 3'b000, 32'hDEADBEEF, 0);
        tbl[7]  = mk(3'b001, 32'h2000, 1, 0, 0,            0, 32'h1000, 3'b000, 3'b000, 32'hDEADBEEF, 0);
        for (int i = 8; i <= 12; i++) begin
            tbl[i] = mk(3'b001, 32'h2000, 1, 0, 0,         1, 32'h2000, 3'b000, 3'b000, 32'hDEADBEEF, 1);
        end
        tbl[13] = mk(3'b001, 32'h2000, 0, 0, 0,            1, 32'h2000, 3'b001, 3'b000, 32'hDEADBEEF, 1);
        tbl[14] = mk(3'b000, 32'h0,    0, 0, 0,            0, 32'h2000, 3'b000, 3'b000, 32'hDEADBEEF, 1);
        tbl[15] = mk(3'b000, 32'h0,    0, 1, 32'h12345678, 0, 32'h2000, 3'b000, 3'b000, 32'hDEADBEEF, 1);
        tbl[16] = mk(3'b000, 32'h0,    0, 0, 0,            0, 32'h2000, 3'b000, 3'b001, 32'h12345678, 0);
        exp_order = '{0, 1, 2, 0, 1, 2};
        three_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk_50M);
        #1;
        chk("reset.read", avm_m0_read, 1'b0);
        chk("reset.address", avm_m0_address, 32'h0);
        chk("reset.req_ready", req_ready, 3'b000);
        chk("reset.rsp_valid", rsp_valid, 3'b000);
        chk("reset.rsp_data", rsp_data, 32'h0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.err", err_unexpected, 1'b0);
        rst = 1'b0;

        // Single request and waitrequest stall, cycle by cycle
        for (int i = 0; i < 17; i++) begin
            av = '0;
            av[31:0] = tbl[i].a0;
            step(tbl[i].v, av, tbl[i].w, tbl[i].dv, tbl[i].d);
            chk($sformatf("vec%0d.read", i), avm_m0_read, tbl[i].e_read);
            chk($sformatf("vec%0d.address", i), avm_m0_address, tbl[i].e_addr);
            chk($sformatf("vec%0d.req_ready", i), req_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d.rsp_valid", i), rsp_valid, tbl[i].e_rspv);
            chk($sformatf("vec%0d.rsp_data", i), rsp_data, tbl[i].e_data);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].e_busy);
        end

        // Round-robin fairness with all requesters held valid
        do_reset();
        dut_grants.delete();
        for (int c = 0; c < 12; c++) begin
            step(3'b111, three_addr, 1'b0, (m_q.size() > 0), $urandom);
        end
        chk("rr.grant_count", dut_grants.size(), 6);
        for (int g = 0; g < 6; g++) begin
            chk($sformatf("rr.grant%0d", g), (g < dut_grants.size()) ? dut_grants[g] : -1, exp_order[g]);
        end
        drain(4);

        // Outstanding limit, then push and pop in the same cycle
        dut_accepts = 0;
        for (int c = 0; c < 12; c++) begin
            step(3'b111, three_addr, 1'b0, 1'b0, 32'h0);
        end
        chk("limit.accepts", dut_accepts, 4);
        chk("limit.read_blocked", avm_m0_read, 1'b0);
        step(3'b111, three_addr, 1'b0, 1'b1, 32'hA5A5_0001);
        step(3'b111, three_addr, 1'b0, 1'b0, 32'h0);
        step(3'b111, three_addr, 1'b0, 1'b1, 32'hA5A5_0002);
        chk("limit.fifth_accept", dut_accepts, 5);
        step(3'b111, three_addr, 1'b0, 1'b0, 32'h0);
        step(3'b111, three_addr, 1'b0, 1'b0, 32'h0);
        chk("pushpop.rearbitrated", avm_m0_read, 1'b1);
        chk("pushpop.sixth_accept", dut_accepts, 6);
        drain(6);
        chk("limit.idle_after_drain", busy, 1'b0);

        // Unexpected read data
        step('0, '0, 1'b0, 1'b1, 32'h0BAD_0BAD);
        step('0, '0, 1'b0, 1'b0, 32'h0);
        chk("err.set", err_unexpected, 1'b1);
        chk("err.no_rsp", rsp_valid, 3'b000);
        drain(3);
        chk("err.sticky", err_unexpected, 1'b1);

        // Asynchronous reset while a command is held on the bus
        av = '0;
        av[31:0] = 32'h0000_4000;
        step(3'b001, av, 1'b1, 1'b0, 32'h0);
        step(3'b001, av, 1'b1, 1'b0, 32'h0);
        chk("rst_mid.read_before", avm_m0_read, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid.read", avm_m0_read, 1'b0);
        chk("rst_mid.address", avm_m0_address, 32'h0);
        chk("rst_mid.req_ready", req_ready, 3'b000);
        chk("rst_mid.rsp_valid", rsp_valid, 3'b000);
        chk("rst_mid.rsp_data", rsp_data, 32'h0);
        chk("rst_mid.busy", busy, 1'b0);
        chk("rst_mid.err", err_unexpected, 1'b0);
        req_valid = '0;
        avm_m0_waitrequest = 1'b0;
        model_reset();
        @(posedge clk_50M);
        #1;
        rst = 1'b0;
        step('0, '0, 1'b0, 1'b1, 32'h5712_A66E);
        step('0, '0, 1'b0, 1'b0, 32'h0);
        chk("rst_mid.straggler_err", err_unexpected, 1'b1);

        // Randomized traffic against the model
        do_reset();
        rq_v = '0;
        rq_a = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rq_v[i] && m_last_ready[i]) rq_v[i] = 1'b0;
                if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
                    rq_v[i] = 1'b1;
                    rq_a[32*i +: 32] = $urandom & 32'hFFFF_FFFC;
                end
            end
            step(rq_v, rq_a, ($urandom_range(0, 3) == 0),
                 (m_q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);
        end
        drain(8);
        chk("random.idle_at_end", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
